seg_scan_driver: RTL and testbench

Time-multiplexed display scanner sitting directly upstream of the 4-to-7 segment decoder in the processor's display path. Captures a DATA_W-bit value from the datapath via a load strobe, double-buffers it so updates never tear mid-frame, and presents one hex nibble at a time to the decoder while driving the matching active-low digit enable. Also provides anti-ghosting guard time and optional leading-zero blanking.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_lzb_mask.sv | 26 ++
 rtl/seg_scan_driver.sv | 127 ++++++++++++
 tb/tb_seg_scan_driver.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the display scan driver: default timing constants,
// the per-slot state type and the digit-count derivation.
package seg_pkg;

    localparam int unsigned DefDataW      = 8;
    localparam int unsigned DefRefreshDiv = 4096;
    localparam int unsigned DefGuard      = 16;

    typedef enum logic {
        StGuard,
        StDrive
    } slot_state_e;

    function automatic int unsigned num_digits(input int unsigned data_w);
        return data_w / 4;
    endfunction

endpackage

// File: rtl/seg_lzb_mask.sv
// Leading-zero blanking mask: bit k is set when digit k and every more
// significant nibble are zero. Digit 0 is never blanked.
module seg_lzb_mask
    import seg_pkg::*;
#(
    parameter int unsigned DATA_W     = DefDataW,
    localparam int unsigned NUM_DIGITS = num_digits(DATA_W)
) (
    input  logic [DATA_W-1:0]     disp_i,
    input  logic                  lzb_en_i,
    output logic [NUM_DIGITS-1:0] blank_mask_o
);

    logic zero_run;

    // Walk from the most significant nibble down; the run breaks at the first nonzero.
    always_comb begin
        blank_mask_o = '0;
        zero_run     = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run        = zero_run && (disp_i[4*k +: 4] == 4'h0);
            blank_mask_o[k] = lzb_en_i && zero_run;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed hex display scanner: double-buffers a loaded word and
// presents one nibble per slot with a matching active-low digit enable.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned REFRESH_DIV = DefRefreshDiv,
    parameter int unsigned GUARD       = DefGuard,
    localparam int unsigned NUM_DIGITS  = num_digits(DATA_W)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [DATA_W-1:0]     data_in,
    input  logic                  lzb_en,
    output logic [3:0]            nibble,
    output logic [NUM_DIGITS-1:0] digit_en_n,
    output logic                  frame_done
);

    localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CntW-1:0] SlotLast = CntW'(REFRESH_DIV - 1);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DIGITS - 1);

    logic [CntW-1:0]       slot_cnt_q, slot_cnt_d;
    logic [IdxW-1:0]       digit_idx_q, digit_idx_d;
    logic [DATA_W-1:0]     pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0]     disp_q, disp_d;
    logic [3:0]            nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0] digit_en_n_q, digit_en_n_d;
    logic                  frame_done_q, frame_done_d;

    logic                  slot_last;
    logic                  frame_end;
    logic [NUM_DIGITS-1:0] blank_mask;
    slot_state_e           slot_state;

    assign slot_last = (slot_cnt_q == SlotLast);
    assign frame_end = slot_last && (digit_idx_q == IdxLast);

    if (GUARD == 0) begin : g_no_guard
        assign slot_state = StDrive;
    end else begin : g_guard
        localparam logic [CntW-1:0] GuardCnt = CntW'(GUARD);
        assign slot_state = (slot_cnt_q < GuardCnt) ? StGuard : StDrive;
    end

    seg_lzb_mask #(
        .DATA_W (DATA_W)
    ) u_lzb_mask (
        .disp_i       (disp_q),
        .lzb_en_i     (lzb_en),
        .blank_mask_o (blank_mask)
    );

    always_comb begin
        slot_cnt_d  = slot_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (slot_last) begin
            slot_cnt_d  = '0;
            digit_idx_d = (digit_idx_q == IdxLast) ? '0 : digit_idx_q + 1'b1;
        end
    end

    // A load on the frame-end cycle bypasses the pending buffer so it is not delayed a frame.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        disp_d     = disp_q;
        if (load) begin
            pend_d     = data_in;
            pend_vld_d = 1'b1;
        end
        if (frame_end) begin
            if (load) begin
                disp_d = data_in;
            end else if (pend_vld_q) begin
                disp_d = pend_q;
            end
            pend_vld_d = 1'b0;
        end
    end

    always_comb begin
        nibble_d     = 4'(disp_q >> {digit_idx_q, 2'b00});
        digit_en_n_d = '1;
        unique case (slot_state)
            StGuard: digit_en_n_d = '1;
            StDrive: begin
                if (!blank_mask[digit_idx_q]) begin
                    digit_en_n_d = ~(NUM_DIGITS'(1) << digit_idx_q);
                end
            end
        endcase
        // Registered so the pulse lines up with the cycle the counters sit at frame end.
        frame_done_d = (slot_cnt_d == SlotLast) && (digit_idx_d == IdxLast);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q   <= '0;
            digit_idx_q  <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            disp_q       <= '0;
            nibble_q     <= 4'h0;
            digit_en_n_q <= '1;
            frame_done_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            digit_idx_q  <= digit_idx_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            disp_q       <= disp_d;
            nibble_q     <= nibble_d;
            digit_en_n_q <= digit_en_n_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign nibble     = nibble_q;
    assign digit_en_n = digit_en_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: a cycle-count model pushes expected outputs per edge for a
// GUARD=2 and a GUARD=0 instance; each is popped and compared after the edge.
module tb_seg_scan_driver;

    localparam int unsigned DataW    = 8;
    localparam int unsigned RefDiv   = 8;
    localparam int unsigned Guard    = 2;
    localparam int unsigned NumDig   = 2;
    localparam int unsigned FrameLen = NumDig * RefDiv;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b1;
    logic       load    = 1'b0;
    logic       lzb_en  = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [3:0] nib_a, nib_b;
    logic [1:0] en_a, en_b;
    logic       fd_a, fd_b;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    logic [7:0] disp_m     = 8'h00;
    logic [7:0] pend_m     = 8'h00;
    logic       pend_vld_m = 1'b0;
    logic [6:0] q_a[$];
    logic [6:0] q_b[$];

    always #5 clk = ~clk;

    seg_scan_driver #(
        .DATA_W      (DataW),
        .REFRESH_DIV (RefDiv),
        .GUARD       (Guard)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .data_in    (data_in),
        .lzb_en     (lzb_en),
        .nibble     (nib_a),
        .digit_en_n (en_a),
        .frame_done (fd_a)
    );

    seg_scan_driver #(
        .DATA_W      (DataW),
        .REFRESH_DIV (RefDiv),
        .GUARD       (0)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .data_in    (data_in),
        .lzb_en     (lzb_en),
        .nibble     (nib_b),
        .digit_en_n (en_b),
        .frame_done (fd_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs after the next edge come from the counter state n edges after reset.
    task automatic tick(input string ph);
        int         s;
        int         d;
        logic       blanked;
        logic [1:0] one_hot;
        logic [1:0] en_drive;
        logic [3:0] exp_nib;
        logic       exp_fd;
        logic [6:0] exp_a;
        logic [6:0] exp_b;
        s        = n % RefDiv;
        d        = (n / RefDiv) % NumDig;
        exp_nib  = 4'(disp_m >> (4 * d));
        blanked  = lzb_en && (d > 0) && ((disp_m >> (4 * d)) == 8'h00);
        one_hot  = 2'b01 << d;
        en_drive = blanked ? 2'b11 : ~one_hot;
        exp_fd   = ((n + 1) % FrameLen) == (FrameLen - 1);
        q_a.push_back({exp_nib, (s < Guard) ? 2'b11 : en_drive, exp_fd});
        q_b.push_back({exp_nib, en_drive, exp_fd});
        if ((n % FrameLen) == (FrameLen - 1)) begin
            if (load) disp_m = data_in;
            else if (pend_vld_m) disp_m = pend_m;
            pend_vld_m = 1'b0;
        end else if (load) begin
            pend_m     = data_in;
            pend_vld_m = 1'b1;
        end
        @(posedge clk);
        #1;
        n++;
        exp_a = q_a.pop_front();
        exp_b = q_b.pop_front();
        check_eq($sformatf("%s_g2@%0d", ph, n), {25'd0, nib_a, en_a, fd_a}, {25'd0, exp_a});
        check_eq($sformatf("%s_g0@%0d", ph, n), {25'd0, nib_b, en_b, fd_b}, {25'd0, exp_b});
        check_eq($sformatf("%s_g0_overlap@%0d", ph, n), {31'd0, en_b == 2'b00}, 32'd0);
    endtask

    task automatic run(input string ph, input int cycles);
        for (int i = 0; i < cycles; i++) tick(ph);
    endtask

    task automatic do_load(input string ph, input logic [7:0] v);
        load    = 1'b1;
        data_in = v;
        tick(ph);
        load    = 1'b0;
        data_in = 8'h00;
    endtask

    task automatic check_reset_outputs(input string ph);
        check_eq({ph, "_nib_g2"}, {28'd0, nib_a}, 32'h0);
        check_eq({ph, "_en_g2"}, {30'd0, en_a}, 32'h3);
        check_eq({ph, "_fd_g2"}, {31'd0, fd_a}, 32'h0);
        check_eq({ph, "_nib_g0"}, {28'd0, nib_b}, 32'h0);
        check_eq({ph, "_en_g0"}, {30'd0, en_b}, 32'h3);
        check_eq({ph, "_fd_g0"}, {31'd0, fd_b}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("por");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;

        // Basic load: 3A appears from the next frame.
        run("idle", 3);
        do_load("ld3a", 8'h3A);
        run("show3a", 2 * FrameLen);

        // Two loads inside one frame: only the last survives.
        while ((n % FrameLen) != 2) tick("align");
        do_load("ld12", 8'h12);
        run("mid", 4);
        do_load("ld34", 8'h34);
        run("show34", 2 * FrameLen);

        // Load landing on the frame-end cycle is shown immediately next frame.
        while ((n % FrameLen) != FrameLen - 1) tick("align");
        do_load("ld56eof", 8'h56);
        run("show56", FrameLen + 3);

        // Leading-zero blanking.
        lzb_en = 1'b1;
        do_load("ld07", 8'h07);
        run("lzb07", 2 * FrameLen);
        do_load("ld00", 8'h00);
        run("lzb00", 2 * FrameLen);
        lzb_en = 1'b0;
        run("lzboff", FrameLen);
        lzb_en = 1'b1;
        do_load("ld90", 8'h90);
        run("lzb90", 2 * FrameLen);
        lzb_en = 1'b0;

        // Async reset mid-slot with a value still pending.
        while ((n % FrameLen) != 3) tick("align");
        do_load("ldab", 8'hAB);
        while ((n % RefDiv) != 4) tick("pend");
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        @(posedge clk);
        @(posedge clk);
        #1 check_reset_outputs("rst_hold");
        rst_n      = 1'b1;
        n          = 0;
        disp_m     = 8'h00;
        pend_m     = 8'h00;
        pend_vld_m = 1'b0;
        run("post_rst", 3 * FrameLen);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
